relogio_ctrl: RTL

Timekeeping controller for the digital clock. Turns the system clock into a 1 Hz enable for the seconds counter and forwards the seconds and minutes carries as enables for the minutes and hours counters. A two-button mode state machine lets the user set hours and minutes. The block sits between the board buttons and the seconds/minutes/hours counter machines, and is the only source of their enable and clear inputs.

---
 rtl/relogio_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/relogio_ctrl.sv
// rtl/relogio_ctrl.sv - timekeeping controller: 1 Hz prescaler, carry forwarding, two-button set-mode FSM
module relogio_ctrl #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       ctrl_clock,
    input  logic       ctrl_reset,
    input  logic       ctrl_btn_mode,
    input  logic       ctrl_btn_inc,
    input  logic       ctrl_carry_seg,
    input  logic       ctrl_carry_min,
    output logic       ctrl_en_seg,
    output logic       ctrl_en_min,
    output logic       ctrl_en_hora,
    output logic       ctrl_clr_seg,
    output logic [1:0] ctrl_modo,
    output logic       ctrl_pisca
);

    localparam int              CW       = $clog2(CLK_HZ);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLK_HZ / 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HORA = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    mode_t          mode;
    mode_t          mode_next;
    logic [2:0]     mode_sync;
    logic [2:0]     inc_sync;
    logic [CW-1:0]  cnt;
    logic           mode_press;
    logic           inc_press;
    logic           cnt_wrap;
    logic           blink_on;

    // bits [1:0] synchronize the button, bit 2 holds the previous synchronized level
    assign mode_press = mode_sync[1] & ~mode_sync[2];
    assign inc_press  = inc_sync[1] & ~inc_sync[2];
    assign cnt_wrap   = (cnt == CNT_MAX);
    assign blink_on   = (cnt < CNT_HALF);

    always_ff @(posedge ctrl_clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            mode      <= RUN;
            mode_sync <= 3'b000;
            inc_sync  <= 3'b000;
            cnt       <= '0;
        end else begin
            mode      <= mode_next;
            mode_sync <= {mode_sync[1:0], ctrl_btn_mode};
            inc_sync  <= {inc_sync[1:0], ctrl_btn_inc};
            if (mode_press || cnt_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // every mode press is a transition, so the increment is dropped whenever mode_press is high
    always_comb begin
        mode_next    = mode;
        ctrl_en_seg  = 1'b0;
        ctrl_en_min  = 1'b0;
        ctrl_en_hora = 1'b0;
        ctrl_clr_seg = 1'b1;
        ctrl_modo    = 2'd0;
        ctrl_pisca   = 1'b1;
        case (mode)
            SET_HORA: begin
                if (mode_press) begin
                    mode_next = SET_MIN;
                end
                ctrl_en_hora = inc_press & ~mode_press;
                ctrl_modo    = 2'd1;
                ctrl_pisca   = blink_on;
            end
            SET_MIN: begin
                if (mode_press) begin
                    mode_next    = RUN;
                    ctrl_clr_seg = 1'b0;
                end
                ctrl_en_min = inc_press & ~mode_press;
                ctrl_modo   = 2'd2;
                ctrl_pisca  = blink_on;
            end
            default: begin
                if (mode_press) begin
                    mode_next = SET_HORA;
                end
                ctrl_en_seg  = cnt_wrap;
                ctrl_en_min  = cnt_wrap & ctrl_carry_seg;
                ctrl_en_hora = cnt_wrap & ctrl_carry_seg & ctrl_carry_min;
            end
        endcase
    end

endmodule
